// File: rtl/alu_uart_interface_pkg.sv
// Shared definitions for the UART-fed ALU sequencer: FSM state encoding and ALU funct codes.
package alu_uart_interface_pkg;

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EVAL    = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_interface_if.sv
// Bundle of UART handshake, ALU operand/result and status signals around the sequencer.
interface alu_uart_interface_if #(
  parameter int N_BITS = 8,
  parameter int N_OP   = 6
) ();
  logic        [7:0]        rx_data;
  logic                     rx_done;
  logic                     tx_done;
  logic signed [N_BITS-1:0] alu_result;
  logic signed [N_BITS-1:0] alu_A;
  logic signed [N_BITS-1:0] alu_B;
  logic        [N_OP-1:0]   alu_Op;
  logic        [7:0]        tx_data;
  logic                     tx_start;
  logic                     busy;
  logic                     overrun;
  logic                     frame_err;

  // master: UART/ALU environment; slave: the sequencer itself
  modport master (
    output rx_data, rx_done, tx_done, alu_result,
    input  alu_A, alu_B, alu_Op, tx_data, tx_start, busy, overrun, frame_err
  );
  modport slave (
    input  rx_data, rx_done, tx_done, alu_result,
    output alu_A, alu_B, alu_Op, tx_data, tx_start, busy, overrun, frame_err
  );
endinterface

// File: rtl/alu_uart_interface_frame_timeout_counter.sv
// Clearable, enable-gated idle counter; tc_o flags the last allowed idle cycle of a frame.
module frame_timeout_counter #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == TC_VAL);
endmodule

// File: rtl/alu_uart_interface.sv
// Collects A/B/Op bytes from UART RX, drives registered ALU operands and returns the
// sign-extended ALU result to UART TX; drops stale partial frames after an idle timeout.
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int N_BITS  = 8,
  parameter int N_OP    = 6,
  parameter int TIMEOUT = 100000
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_uart_interface_if.slave bus
);
  state_t                   state_q, state_d;
  logic signed [N_BITS-1:0] a_q, a_d, b_q, b_d;
  logic        [N_OP-1:0]   op_q, op_d;
  logic        [7:0]        tx_q, tx_d;
  logic                     ovr_q, ovr_d, ferr_q, ferr_d;
  logic                     collecting, busy_w, tmo_tc, cnt_clr;
  logic                     unused_rx_hi;

  function automatic logic [7:0] sext8(input logic signed [N_BITS-1:0] v);
    return 8'(v);
  endfunction

  assign collecting   = (state_q == S_WAIT_B) || (state_q == S_WAIT_OP);
  assign busy_w       = (state_q == S_EVAL) || (state_q == S_SEND) || (state_q == S_WAIT_TX);
  assign cnt_clr      = !collecting || bus.rx_done || tmo_tc;
  assign unused_rx_hi = ^bus.rx_data;

  frame_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (collecting),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tx_d    = tx_q;
    ferr_d  = 1'b0;
    // bytes arriving while a result is in flight are lost, and that loss is remembered
    ovr_d   = ovr_q | (busy_w & bus.rx_done);
    case (state_q)
      S_WAIT_A: if (bus.rx_done) begin
        a_d     = bus.rx_data[N_BITS-1:0];
        state_d = S_WAIT_B;
      end
      S_WAIT_B: if (bus.rx_done) begin
        b_d     = bus.rx_data[N_BITS-1:0];
        state_d = S_WAIT_OP;
      end else if (tmo_tc) begin
        ferr_d  = 1'b1;
        state_d = S_WAIT_A;
      end
      S_WAIT_OP: if (bus.rx_done) begin
        op_d    = bus.rx_data[N_OP-1:0];
        state_d = S_EVAL;
      end else if (tmo_tc) begin
        ferr_d  = 1'b1;
        state_d = S_WAIT_A;
      end
      S_EVAL: begin
        tx_d    = sext8(bus.alu_result);
        state_d = S_SEND;
      end
      S_SEND:    state_d = S_WAIT_TX;
      S_WAIT_TX: if (bus.tx_done) state_d = S_WAIT_A;
      default:   state_d = S_WAIT_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.alu_A     = a_q;
  assign bus.alu_B     = b_q;
  assign bus.alu_Op    = op_q;
  assign bus.tx_data   = tx_q;
  assign bus.tx_start  = (state_q == S_SEND);
  assign bus.busy      = busy_w;
  assign bus.overrun   = ovr_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
- Sequencing stage that sits directly upstream of the ALU and also collects its output.
- Collects three bytes (A, B, Op) from the UART receiver and presents them to the ALU as registered operands.
- Captures the combinational ALU result and hands it to the UART transmitter as one byte.
- Turns the purely combinational ALU into a host-driven, frame-based calculator.

Parameters:
- N_BITS, 8, operand/result width; must be ≤ 8 because operands arrive one byte each.
- N_OP, 6, opcode width (funct field).
- TIMEOUT, 100000, maximum idle gap in clk cycles between bytes of one frame.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  byte from UART RX, valid while rx_done=1
- rx_done  in  1  one-cycle strobe: new RX byte
- tx_done  in  1  one-cycle strobe: TX finished the last byte
- alu_result  in  N_BITS  signed ALU output (combinational from alu_A/alu_B/alu_Op)
- alu_A  out  N_BITS  signed operand A, registered
- alu_B  out  N_BITS  signed operand B, registered
- alu_Op  out  N_OP  opcode, registered
- tx_data  out  8  result byte for TX
- tx_start  out  1  one-cycle strobe: start transmission of tx_data
- busy  out  1  high from EVAL through WAIT_TX
- overrun  out  1  sticky: rx_done arrived while busy; cleared only by reset
- frame_err  out  1  one-cycle pulse when a partial frame is dropped on timeout

Behaviour:
- Reset (rst_n=0, asynchronous): state=WAIT_A; alu_A, alu_B, alu_Op, tx_data=0; tx_start, busy, overrun, frame_err=0; timeout counter=0.
- Reset mid-frame or mid-transmission aborts immediately. Partially received bytes are discarded and no tx_start is issued.
- States: WAIT_A, WAIT_B, WAIT_OP, EVAL, SEND, WAIT_TX.
- WAIT_A: on rx_done, alu_A <= rx_data[N_BITS-1:0]; go to WAIT_B.
- WAIT_B: on rx_done, alu_B <= rx_data[N_BITS-1:0]; go to WAIT_OP.
- WAIT_OP: on rx_done, alu_Op <= rx_data[N_OP-1:0], with bits [7:N_OP] ignored; go to EVAL.
- EVAL: single cycle in which the ALU output settles. At its end, tx_data <= alu_result sign-extended to 8 bits; go to SEND.
- SEND: tx_start=1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: on tx_done go to WAIT_A. A tx_done in any other state is ignored.
- Latency: Op byte strobe sampled at edge t → tx_start high during cycle t+2.
- alu_A, alu_B, alu_Op hold their values until overwritten by the next frame. The ALU output therefore stays observable between frames.
- Timeout counter:
  - Runs only in WAIT_B and WAIT_OP; cleared on every accepted rx_done and on entry to WAIT_A.
  - When it reaches TIMEOUT-1 with no rx_done: go to WAIT_A and pulse frame_err for one cycle. Operand registers keep their last values.
  - If rx_done coincides with the timeout cycle, the byte wins: it is accepted and there is no frame_err.
- rx_done in EVAL, SEND or WAIT_TX: byte dropped and overrun <= 1; state unaffected.
- rx_done in the same cycle as tx_done in WAIT_TX: tx_done is honoured (go to WAIT_A), the byte is dropped and overrun is set.
- busy = (state ∈ {EVAL, SEND, WAIT_TX}), decoded from registered state.

Decomposition:
- Shared package holds:
  - state encoding typedef (3-bit) for the six states;
  - opcode constants ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111, also used by the ALU and its bench.
- One natural sub-module: frame_timeout_counter, a clearable, enable-gated counter with a terminal-count output.

Test Plan:
- Frame 0x05, 0x03, 0x20 with tx_done returned 50 cycles after tx_start → alu_A=5, alu_B=3, alu_Op=0x20; tx_start 2 cycles after the Op strobe; tx_data=0x08; back to WAIT_A after tx_done.
- Frame 0x03, 0x05, 0x22 (SUB) → tx_data=0xFE (−2); then frame 0xF0, 0x3C, 0x24 (AND) → tx_data=0x30.
- Send 0x07 only, then idle TIMEOUT cycles (TIMEOUT=16 in bench) → frame_err pulses once at cycle 16; next frame 0x01, 0x01, 0x20 → tx_data=0x02.
- During WAIT_TX inject rx_done with 0xAA → overrun=1 and stays 1; the following frame still completes correctly; only rst_n clears overrun.
- Assert rst_n=0 asynchronously between the B and Op bytes → all outputs zero immediately; after release, no tx_start until a full new 3-byte frame is received.
- rx_done on exactly the timeout cycle in WAIT_B → byte accepted as B, no frame_err, state WAIT_OP.
